// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB requester bridging a valid/ready command port to APB SETUP/ACCESS transfers
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  i_pclk,
    input  logic                  i_preset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_rsp_timeout,
    output logic                  o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [ADDR_WIDTH-1:0] o_paddr,
    output logic [DATA_WIDTH-1:0] o_pwdata,
    input  logic [DATA_WIDTH-1:0] i_prdata,
    input  logic                  i_pready,
    input  logic                  i_pslverr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // TIMEOUT=0 still needs a 1-bit counter; it just saturates and never aborts.
    localparam int              CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]            r_state;
    logic [CW-1:0]         r_wait_cnt;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic                  w_timeout_hit;

    assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST) && !i_pready;

    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_pwrite <= i_cmd_write;
                        r_paddr  <= i_cmd_addr;
                        r_pwdata <= i_cmd_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (i_pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= i_pslverr;
                        r_rsp_rdata   <= r_pwrite ? '0 : i_prdata;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (w_timeout_hit) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready   = (r_state == ST_IDLE) && !i_preset;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_psel        = r_psel;
    assign o_penable     = r_penable;
    assign o_pwrite      = r_pwrite;
    assign o_paddr       = r_paddr;
    assign o_pwdata      = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_chk  = 0;
    int n_fail = 0;

    apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .i_pclk        (clk),
        .i_preset      (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_write   (cmd_write),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_wdata   (cmd_wdata),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_rsp_timeout (rsp_timeout),
        .o_psel        (psel),
        .o_penable     (penable),
        .o_pwrite      (pwrite),
        .o_paddr       (paddr),
        .o_pwdata      (pwdata),
        .i_prdata      (prdata),
        .i_pready      (pready),
        .i_pslverr     (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    property p_apb_stable;
        @(posedge clk) disable iff (rst)
            (psel && !(penable && pready)) |=> ($stable(paddr) && $stable(pwdata) && $stable(pwrite));
    endproperty
    a_apb_stable: assert property (p_apb_stable)
        else begin
            n_fail++;
            $error("FAIL apb_stable: paddr=0x%0h pwdata=0x%0h changed mid-transfer", paddr, pwdata);
        end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a command now (one tick after an edge) and walk it through SETUP/ACCESS.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input int waits, input logic err, input logic [31:0] rd,
                        input logic hold_valid);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        check("cmd_ready_idle", cmd_ready, 1);
        step();
        cmd_valid = hold_valid;
        cmd_write = ~wr;
        cmd_addr  = ~a;
        cmd_wdata = ~d;
        check("setup_psel", psel, 1);
        check("setup_penable", penable, 0);
        check("setup_paddr", paddr, a);
        check("setup_pwrite", pwrite, wr);
        check("setup_pwdata", pwdata, d);
        check("setup_rsp_valid", rsp_valid, 0);
        check("setup_cmd_ready", cmd_ready, 0);
        step();
        for (int i = 0; i <= waits; i++) begin
            check("access_psel", psel, 1);
            check("access_penable", penable, 1);
            check("access_paddr", paddr, a);
            check("access_pwdata", pwdata, d);
            check("access_rsp_valid", rsp_valid, 0);
            pready  = (i == waits);
            pslverr = (i == waits) ? err : ~err;
            prdata  = (i == waits) ? rd : (32'hBAD0_0000 | 32'(i));
            step();
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h5A5A_5A5A;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_err", rsp_err, err);
        check("rsp_timeout", rsp_timeout, 0);
        check("rsp_rdata", rsp_rdata, wr ? 32'h0 : rd);
        check("rsp_psel", psel, 0);
        check("rsp_penable", penable, 0);
        check("rsp_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        logic        r_wr;
        logic        r_err;
        logic [7:0]  r_a;
        logic [31:0] r_d;
        logic [31:0] r_rd;
        int          r_w;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 32'h0;
        prdata    = 32'h0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        step();
        step();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);
        step();

        // 1: zero-wait write
        xfer(1'b1, 8'h0A, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0);
        step();
        check("t1_rsp_valid_one_cycle", rsp_valid, 0);
        check("t1_paddr_hold_idle", paddr, 8'h0A);

        // 3: completer error on write, next command still accepted
        xfer(1'b1, 8'hFF, 32'h1234_5678, 0, 1'b1, 32'h0, 1'b0);
        step();
        check("t3_err_held", rsp_err, 1);

        // 2: read with three wait states
        xfer(1'b0, 8'h0A, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
        step();
        check("t2_rdata_held", rsp_rdata, 32'hDEAD_BEEF);

        // 4: read that never completes aborts after 16 ACCESS cycles
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h33;
        check("t4_cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            check("t4_penable", penable, 1);
            check("t4_no_rsp", rsp_valid, 0);
            pready = 1'b0;
            prdata = 32'hCAFE_0000 | 32'(i);
            step();
        end
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_err", rsp_err, 1);
        check("t4_rsp_timeout", rsp_timeout, 1);
        check("t4_rsp_rdata", rsp_rdata, 0);
        check("t4_psel", psel, 0);
        check("t4_penable_off", penable, 0);
        step();
        check("t4_rsp_valid_drop", rsp_valid, 0);
        check("t4_timeout_held", rsp_timeout, 1);

        // 5: back-to-back commands with cmd_valid held high
        for (int k = 0; k < 30; k++) begin
            r_wr  = 1'($urandom_range(0, 1));
            r_err = 1'($urandom_range(0, 1));
            r_a   = 8'($urandom);
            r_d   = $urandom;
            r_rd  = $urandom;
            r_w   = int'($urandom_range(0, 4));
            xfer(r_wr, r_a, r_d, r_w, r_err, r_rd, (k != 29));
        end
        step();
        check("t5_idle_after_burst", psel, 0);

        // 6: reset asserted during ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h44;
        cmd_wdata = 32'h0BAD_F00D;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("t6_in_access", penable, 1);
        rst = 1'b1;
        #1;
        check("t6_psel_async", psel, 0);
        check("t6_penable_async", penable, 0);
        check("t6_cmd_ready_rst", cmd_ready, 0);
        check("t6_no_rsp", rsp_valid, 0);
        check("t6_err_cleared", rsp_err, 0);
        step();
        check("t6_no_rsp_hold", rsp_valid, 0);
        rst = 1'b0;
        #1;
        check("t6_cmd_ready_release", cmd_ready, 1);
        check("t6_paddr_reset", paddr, 0);
        step();
        check("t6_no_late_rsp", rsp_valid, 0);
        xfer(1'b0, 8'h55, 32'h0, 1, 1'b0, 32'h1357_9BDF, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
